// File: rtl/pmem_responder.sv
// pmem_responder: line-granularity memory endpoint for the 256-bit pmem_* bus.
// Accepts one line read or write at a time, waits LATENCY cycles and then
// pulses pmem_resp for a single cycle. Storage is an internal line array.
// Optional feature macro: PMEM_STABLE_CHECK_EN. When it is defined, request
// inputs are compared against the captured command during BUSY/RESP, and any
// change sets proto_err.
//
// Handshake: the initiator raises pmem_read or pmem_write and holds it, with
// address and wdata, until pmem_resp. It must drop the request in the cycle
// after pmem_resp. A request still high in IDLE is taken as a new transaction.
module pmem_responder #(
    parameter int LINES   = 64,
    parameter int LATENCY = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         pmem_read,
    input  logic         pmem_write,
    input  logic [31:0]  pmem_address,
    input  logic [255:0] pmem_wdata,
    output logic         pmem_resp,
    output logic [255:0] pmem_rdata,
    output logic         proto_err
);

    localparam int IDX_W = $clog2(LINES);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_next;

    logic               r_is_write;
    logic [IDX_W-1:0]   r_idx;
    logic [255:0]       r_wdata;
    logic [255:0]       r_rdata;
    logic               r_proto_err;

    logic [255:0]       r_mem [LINES];

    logic               w_req;
    logic               w_accept;
    logic               w_both;
    logic               w_enter_resp;
    logic               w_rd_cmd;
    logic               w_stable_err;
    logic [IDX_W-1:0]   w_live_idx;
    logic [IDX_W-1:0]   w_rd_idx;
    logic               w_unused_addr;

    // Address bits below the line offset and above the index never matter.
    assign w_unused_addr = ^{pmem_address[4:0], pmem_address[31:5+IDX_W]};

    assign w_live_idx = pmem_address[5 +: IDX_W];
    assign w_req      = pmem_read | pmem_write;
    assign w_accept   = (r_state == ST_IDLE) && w_req;
    assign w_both     = w_accept && pmem_read && pmem_write;

    // A simultaneous read+write is performed as a write, so a read command
    // is only a read with write low. With LATENCY=1 the read enters RESP
    // straight from IDLE and must use the live command and index.
    assign w_rd_cmd = (r_state == ST_IDLE) ? (pmem_read & ~pmem_write) : ~r_is_write;
    assign w_rd_idx = (r_state == ST_IDLE) ? w_live_idx : r_idx;
    assign w_enter_resp = (w_state_next == ST_RESP) && (r_state != ST_RESP);

    // Next-state and counter logic; the counter reaching 0 ends BUSY.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    if (LATENCY == 1) begin
                        w_state_next = ST_RESP;
                    end else begin
                        w_state_next = ST_BUSY;
                        w_cnt_next   = CNT_W'(LATENCY - 1);
                    end
                end
            end
            ST_BUSY: begin
                w_cnt_next = r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    w_state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    // State and latency counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Capture the command at acceptance; later input changes are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_is_write <= 1'b0;
            r_idx      <= '0;
            r_wdata    <= '0;
        end else if (w_accept) begin
            r_is_write <= pmem_write;
            r_idx      <= w_live_idx;
            r_wdata    <= pmem_wdata;
        end
    end

    // Read data is loaded at the edge entering RESP and held until the next read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (w_enter_resp && w_rd_cmd) begin
            r_rdata <= r_mem[w_rd_idx];
        end
    end

    // Write commits at the edge that ends RESP; reset drops the FSM out of
    // RESP asynchronously, so an interrupted write never reaches the array.
    always_ff @(posedge clk) begin
        if (r_state == ST_RESP && r_is_write) begin
            r_mem[r_idx] <= r_wdata;
        end
    end

`ifdef PMEM_STABLE_CHECK_EN
    logic        r_cap_read;
    logic [26:0] r_cap_addr;

    // Extra copies of the request needed only for the stability comparison.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cap_read <= 1'b0;
            r_cap_addr <= '0;
        end else if (w_accept) begin
            r_cap_read <= pmem_read;
            r_cap_addr <= pmem_address[31:5];
        end
    end

    assign w_stable_err = ((r_state == ST_BUSY) || (r_state == ST_RESP)) &&
                          ((pmem_read != r_cap_read) ||
                           (pmem_write != r_is_write) ||
                           (pmem_address[31:5] != r_cap_addr) ||
                           (r_is_write && (pmem_wdata != r_wdata)));
`else
    assign w_stable_err = 1'b0;
`endif

    // Sticky protocol-violation flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_proto_err <= 1'b0;
        end else if (w_both || w_stable_err) begin
            r_proto_err <= 1'b1;
        end
    end

    assign pmem_resp  = (r_state == ST_RESP);
    assign pmem_rdata = r_rdata;
    assign proto_err  = r_proto_err;

endmodule
